// File: rtl/usb_endpoint_in_multibuf.sv
// Host-OUT data endpoint with NUM_BUFS packet slots, data-toggle tracking and ACK/NAK/STALL replies.
// Optional drop statistics: define USB_EP_IN_MULTIBUF_DROP_STATS_EN.
module usb_endpoint_in_multibuf #(
  parameter int NUM_BUFS        = 2,
  parameter int MAX_PACKET_SIZE = 64,
  parameter bit IS_ISO          = 1'b0,
  parameter int DATA_WID        = 8,
  localparam int SW = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1,
  localparam int CW = $clog2(MAX_PACKET_SIZE + 1)
) (
  input  logic                clk12_i,
  input  logic                rst_i,
  input  logic                gotTransStartPacket_i,
  input  logic                byteIsData_i,
  input  logic                resetDataToggle_i,
  input  logic                halt_i,
  input  logic                EP_IN_dataValid_i,
  input  logic [DATA_WID-1:0] EP_IN_data_i,
  input  logic                EP_IN_fillTransDone_i,
  input  logic                EP_IN_fillTransSuccess_i,
  output logic                EP_IN_full_o,
  input  logic                EP_IN_popData_i,
  input  logic                EP_IN_popTransDone_i,
  input  logic                EP_IN_popTransSuccess_i,
  output logic                EP_IN_dataAvailable_o,
  output logic [DATA_WID-1:0] EP_IN_data_o,
  output logic                EP_IN_isLast_o,
  output logic [CW-1:0]       EP_IN_pktLen_o,
  output logic                respValid_o,
  output logic                respHandshakePID_o,
  output logic [1:0]          respPacketID_o,
  output logic [7:0]          dropCount_o
);
  localparam logic [1:0] RES_ACK   = 2'd0;
  localparam logic [1:0] RES_NAK   = 2'd1;
  localparam logic [1:0] RES_STALL = 2'd2;
  localparam int DEPTH = NUM_BUFS * MAX_PACKET_SIZE;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [CW-1:0] MPS_C = CW'(MAX_PACKET_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_PID, ST_RX, ST_DROP_DUP, ST_DROP_NAK, ST_DROP_STALL
  } state_t;

  state_t                state_r, state_s;
  logic [DATA_WID-1:0]   mem_r [DEPTH];
  logic [NUM_BUFS-1:0]   committed_r;
  logic [CW-1:0]         len_r [NUM_BUFS];
  logic [SW-1:0]         wr_slot_r, rd_slot_r;
  logic [CW-1:0]         wr_off_r, rd_off_r;
  logic                  ovf_r, toggle_r, resp_valid_r, full_r;
  logic [1:0]            resp_code_r;

  logic                  commit_s, discard_s, wr_en_s, ovf_set_s, clear_resp_s, resp_set_s;
  logic [1:0]            resp_code_s;
  logic                  pid_strobe_s, byte_strobe_s, slot_free_s;
  logic                  head_committed_s, avail_s, free_s;
  logic [CW-1:0]         head_len_s;
  logic [NUM_BUFS-1:0]   free_mask_s, commit_mask_s, committed_next_s;
  logic [AW-1:0]         wr_addr_s, rd_addr_s;

  function automatic logic [SW-1:0] next_slot(input logic [SW-1:0] s);
    if (s == SW'(NUM_BUFS - 1)) next_slot = {SW{1'b0}};
    else                        next_slot = s + SW'(1);
  endfunction

  assign pid_strobe_s     = EP_IN_dataValid_i && !byteIsData_i;
  assign byte_strobe_s    = EP_IN_dataValid_i && byteIsData_i;
  assign head_committed_s = committed_r[rd_slot_r];
  assign head_len_s       = head_committed_s ? len_r[rd_slot_r] : {CW{1'b0}};
  assign avail_s          = head_committed_s && (rd_off_r < head_len_s);
  assign free_s           = EP_IN_popTransDone_i && EP_IN_popTransSuccess_i && head_committed_s;
  assign free_mask_s      = free_s ? (NUM_BUFS'(1) << rd_slot_r) : {NUM_BUFS{1'b0}};
  assign commit_mask_s    = commit_s ? (NUM_BUFS'(1) << wr_slot_r) : {NUM_BUFS{1'b0}};
  // A slot released this cycle is already usable by the PID check below.
  assign committed_next_s = (committed_r & ~free_mask_s) | commit_mask_s;
  assign slot_free_s      = !(committed_r[wr_slot_r] && !free_mask_s[wr_slot_r]);
  assign wr_addr_s        = AW'(int'(wr_slot_r) * MAX_PACKET_SIZE + int'(wr_off_r));
  assign rd_addr_s        = AW'(int'(rd_slot_r) * MAX_PACKET_SIZE + int'(rd_off_r));

  assign EP_IN_full_o          = full_r;
  assign EP_IN_dataAvailable_o = avail_s;
  assign EP_IN_data_o          = avail_s ? mem_r[rd_addr_s] : {DATA_WID{1'b0}};
  assign EP_IN_isLast_o        = avail_s && (rd_off_r == head_len_s - CW'(1));
  assign EP_IN_pktLen_o        = head_len_s;
  assign respValid_o           = resp_valid_r;
  assign respHandshakePID_o    = resp_valid_r;
  assign respPacketID_o        = resp_code_r;

  always_comb begin
    state_s      = state_r;
    commit_s     = 1'b0;
    discard_s    = 1'b0;
    wr_en_s      = 1'b0;
    ovf_set_s    = 1'b0;
    clear_resp_s = 1'b0;
    resp_set_s   = 1'b0;
    resp_code_s  = RES_ACK;
    case (state_r)
      ST_IDLE: begin
        if (gotTransStartPacket_i) begin
          state_s      = ST_WAIT_PID;
          clear_resp_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_PID: begin
        if (EP_IN_fillTransDone_i)            state_s = ST_IDLE;
        else if (!pid_strobe_s)               state_s = ST_WAIT_PID;
        else if (halt_i)                      state_s = ST_DROP_STALL;
        else if (!slot_free_s)                state_s = ST_DROP_NAK;
        else if (!IS_ISO && (EP_IN_data_i[3] != toggle_r)) state_s = ST_DROP_DUP;
        else                                  state_s = ST_RX;
      end
      ST_RX: begin
        if (EP_IN_fillTransDone_i) begin
          state_s = ST_IDLE;
          if (EP_IN_fillTransSuccess_i && !ovf_r) begin
            commit_s   = 1'b1;
            resp_set_s = !IS_ISO;
          end else begin
            discard_s = 1'b1;
          end
        end else if (byte_strobe_s) begin
          if (wr_off_r == MPS_C) ovf_set_s = 1'b1;
          else                   wr_en_s   = 1'b1;
        end else begin
          state_s = ST_RX;
        end
      end
      ST_DROP_DUP, ST_DROP_NAK, ST_DROP_STALL: begin
        if (EP_IN_fillTransDone_i) begin
          state_s    = ST_IDLE;
          resp_set_s = !IS_ISO;
          if (state_r == ST_DROP_NAK)        resp_code_s = RES_NAK;
          else if (state_r == ST_DROP_STALL) resp_code_s = RES_STALL;
          else                               resp_code_s = RES_ACK;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Slot storage; contents need no reset since committed flags gate every read.
  always_ff @(posedge clk12_i) begin
    if (wr_en_s) mem_r[wr_addr_s] <= EP_IN_data_i;
  end

  // FSM state, write/read pointers, slot bookkeeping, toggle and response registers.
  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      committed_r  <= {NUM_BUFS{1'b0}};
      for (int i = 0; i < NUM_BUFS; i++) len_r[i] <= {CW{1'b0}};
      wr_slot_r    <= {SW{1'b0}};
      rd_slot_r    <= {SW{1'b0}};
      wr_off_r     <= {CW{1'b0}};
      rd_off_r     <= {CW{1'b0}};
      ovf_r        <= 1'b0;
      toggle_r     <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_code_r  <= RES_ACK;
      full_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      committed_r <= committed_next_s;
      full_r      <= &committed_next_s;
      if (commit_s) begin
        len_r[wr_slot_r] <= wr_off_r;
        wr_slot_r        <= next_slot(wr_slot_r);
        wr_off_r         <= {CW{1'b0}};
        ovf_r            <= 1'b0;
      end else if (discard_s) begin
        wr_off_r <= {CW{1'b0}};
        ovf_r    <= 1'b0;
      end else if (wr_en_s) begin
        wr_off_r <= wr_off_r + CW'(1);
      end else if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
      if (resetDataToggle_i) toggle_r <= 1'b0;
      else if (commit_s)     toggle_r <= ~toggle_r;
      if (clear_resp_s) begin
        resp_valid_r <= 1'b0;
      end else if (resp_set_s) begin
        resp_valid_r <= 1'b1;
        resp_code_r  <= resp_code_s;
      end
      if (EP_IN_popTransDone_i) begin
        rd_off_r <= {CW{1'b0}};
        if (free_s) rd_slot_r <= next_slot(rd_slot_r);
      end else if (EP_IN_popData_i && avail_s) begin
        rd_off_r <= rd_off_r + CW'(1);
      end
    end
  end

`ifdef USB_EP_IN_MULTIBUF_DROP_STATS_EN
  logic       drop_s;
  logic [7:0] drop_cnt_r;
  assign drop_s = EP_IN_fillTransDone_i &&
                  (((state_r == ST_RX) && !(EP_IN_fillTransSuccess_i && !ovf_r)) ||
                   (state_r == ST_DROP_DUP) || (state_r == ST_DROP_NAK));
  // Saturating count of discarded, duplicate and NAKed packets.
  always_ff @(posedge clk12_i) begin
    if (rst_i)                               drop_cnt_r <= 8'd0;
    else if (drop_s && drop_cnt_r != 8'hFF)  drop_cnt_r <= drop_cnt_r + 8'd1;
  end
  assign dropCount_o = drop_cnt_r;
`else
  assign dropCount_o = 8'd0;
`endif

endmodule

// File: doc/usb_endpoint_in_multibuf.md
Name: usb_endpoint_in_multibuf

Overview:
Parametrised successor of the single-FIFO device-IN (host-OUT data) endpoint. Stores received DATA packets into NUM_BUFS packet slots (ping-pong when 2). Tracks the data toggle and drops repeated packets. Answers ACK/NAK/STALL per transaction, and answers nothing for isochronous endpoints. Sits between the packet receiver/protocol engine and the device-side consumer; one instance per OUT-from-host endpoint.

Parameters:
NUM_BUFS, 2, packet slots (1..8); slot index width SW = max(1, clog2(NUM_BUFS))
MAX_PACKET_SIZE, 64, bytes per slot (8..1023); count width CW = clog2(MAX_PACKET_SIZE+1)
IS_ISO, 0, 1 = isochronous: no toggle check, no handshake
DATA_WID, 8, byte width

Ports:
clk12_i  in  1  12 MHz clock
rst_i  in  1  synchronous active-high reset
gotTransStartPacket_i  in  1  token for this endpoint received (1-cycle pulse)
byteIsData_i  in  1  0 = current byte is the PID, 1 = payload
resetDataToggle_i  in  1  configuration event: expected toggle := DATA0
halt_i  in  1  endpoint halted (STALL)
EP_IN_dataValid_i  in  1  receive byte strobe
EP_IN_data_i  in  DATA_WID  received byte (PID or payload)
EP_IN_fillTransDone_i  in  1  end of data packet
EP_IN_fillTransSuccess_i  in  1  CRC/PID ok, qualified by fillTransDone
EP_IN_full_o  out  1  no free slot
EP_IN_popData_i  in  1  consume one byte
EP_IN_popTransDone_i  in  1  consumer finished the slot
EP_IN_popTransSuccess_i  in  1  1 = free the slot, 0 = rewind it
EP_IN_dataAvailable_o  out  1  unread byte in head slot
EP_IN_data_o  out  DATA_WID  head byte (first-word-fall-through)
EP_IN_isLast_o  out  1  head byte is the last of the packet
EP_IN_pktLen_o  out  CW  length of the head slot
respValid_o  out  1  handshake response valid
respHandshakePID_o  out  1  1 = handshake PID
respPacketID_o  out  2  RES_ACK / RES_NAK / RES_STALL
dropCount_o  out  8  dropped-packet counter (see optional feature)

Behaviour:
- Reset: all slots empty, write/read slot = 0, byte counters = 0, expected toggle = 0, FSM = IDLE. EP_IN_full_o=0, dataAvailable_o=0, isLast_o=0, pktLen_o=0, respValid_o=0, respHandshakePID_o=0, respPacketID_o=RES_ACK, dropCount_o=0. Reset mid-packet discards everything.
- Storage: one RAM of NUM_BUFS*MAX_PACKET_SIZE entries. Address = slot*MAX_PACKET_SIZE + offset. A per-slot committed flag and length register are kept.
- FSM IDLE: gotTransStartPacket_i clears respValid_o and goes to WAIT_PID.
- WAIT_PID: on dataValid with byteIsData_i=0, sample toggle = EP_IN_data_i[3].
  - Go to DROP_STALL if halt_i.
  - Else go to DROP_NAK if no free slot.
  - Else go to DROP_DUP if !IS_ISO and toggle != expected.
  - Else go to RX.
- RX: each payload strobe writes the byte at the current write offset; offset increments.
  - A byte arriving when offset == MAX_PACKET_SIZE sets an overflow flag and the byte is not written.
- DROP_*: payload is ignored.
- fillTransDone_i in any non-IDLE state returns the FSM to IDLE. Response is registered and visible the cycle after fillTransDone:
  - RX, success, no overflow: commit slot (length = offset); write slot advances mod NUM_BUFS; toggle flips; ACK.
  - RX, failure or overflow: slot not committed, offset cleared. No response (respValid_o stays 0); dropCount increments.
  - DROP_DUP: ACK, toggle unchanged, dropCount increments.
  - DROP_NAK: NAK, dropCount increments.
  - DROP_STALL: STALL.
  - IS_ISO: respValid_o never asserts. A failed ISO packet is discarded.
- Response outputs are held until the next gotTransStartPacket_i or reset. respHandshakePID_o = respValid_o.
- resetDataToggle_i has priority over a same-cycle toggle flip: the result is 0.
- EP_IN_full_o = all slots committed.
- Read path: head = read slot.
  - dataAvailable_o = head committed && read offset < length.
  - isLast_o = dataAvailable_o && offset == length-1.
  - popData_i while !dataAvailable_o is ignored.
  - popTransDone with success: free the head, read slot advances, offset := 0. Without success: offset := 0 and the slot is kept.
- A slot freed in the same cycle that its PID is checked counts as free: full is evaluated after pop-side updates.
- Zero-length packet: committed with length 0; dataAvailable_o stays 0 and pktLen_o=0. Consumer frees it via popTransDone.

Optional Feature:
USB_EP_IN_MULTIBUF_DROP_STATS_EN
- Defined: dropCount_o is an 8-bit saturating counter (stops at 255). It increments on every dropped or NAKed packet and clears on rst_i.
- Not defined: dropCount_o is tied to 0 and no counter logic is generated.

Test Plan:
- DATA0 PID 0xC3 + 5 bytes 01..05, success -> ACK; pktLen_o=5; pops return 01..05; isLast_o on 05; expected toggle becomes 1.
- Send DATA0 again after a success (duplicate) -> ACK, nothing stored, dropCount_o=1 (macro defined).
- NUM_BUFS=2: two DATA packets, no pops -> full_o=1; third packet -> NAK. Pop+success one slot, retry -> ACK.
- halt_i=1, any DATA -> STALL; no slot consumed; toggle unchanged.
- MAX_PACKET_SIZE=8, 9 payload bytes -> no response, slot not committed, full_o=0.
- Pop 2 bytes, popTransDone with success=0 -> rewind; first byte re-presented, pktLen_o unchanged. resetDataToggle_i with a same-cycle success -> expected toggle 0.
